deser_field: RTL and testbench

- Inverse of the field serializer: decodes one protobuf field (tag + payload) from a serialized input buffer and stores the value into its destination slot in the in-memory object.
- Handles scalar types only: varint, zigzag, fixed32 and fixed64. Strings, bytes and nested messages belong to a later block.
- Sits beside the serializer on the shared 8-lane DRAM port. A table walker drives it one entry at a time and uses next_src_addr to advance through the buffer.

---
 rtl/deser_field.sv | 231 +++++++++++++++++++++++
 tb/tb_deser_field.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deser_field.sv
// rtl/deser_field.sv - decode one scalar protobuf field from DRAM and store it into the object
// Purpose: fetches 16 bytes at src_addr over the 8-lane DRAM port (two reads), decodes tag and
//          scalar payload (varint, zigzag, fixed32, fixed64), then writes the value to dst_addr.
// Ports:   clk/reset (sync, active-low); en/ready request handshake; src_addr, dst_addr,
//          exp_field_id, field_type describe the entry; done pulses with error, err_code,
//          bytes_consumed, next_src_addr; dram_* is the shared 8-lane byte port.
module deser_field #(
  parameter int MAX_TAG_BYTES = 5,
  parameter int MAX_VAL_BYTES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [63:0]      src_addr,
  input  logic [63:0]      dst_addr,
  input  logic [28:0]      exp_field_id,
  input  logic [4:0]       field_type,
  output logic             ready,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [3:0]       bytes_consumed,
  output logic [63:0]      next_src_addr,
  output logic [7:0]       dram_en,
  output logic             dram_rdwr,
  output logic [7:0][63:0] dram_addr,
  output logic [7:0][7:0]  dram_data_out,
  input  logic [7:0][7:0]  dram_data_in,
  input  logic [7:0]       dram_valid
);
  localparam int TAG_W = 7 * MAX_TAG_BYTES;

  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_RDW0, S_RD1, S_RDW1, S_DECODE, S_WR, S_WRW, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [63:0]      src_q, dst_q;
  logic [28:0]      exp_q;
  logic [4:0]       type_q;
  logic [15:0][7:0] buf_q;
  logic [63:0]      value_q;
  logic [7:0]       mask_q;
  logic [1:0]       code_q;
  logic [3:0]       cons_q;

  logic [TAG_W-1:0] tag_acc;
  logic             tag_ok;
  logic [3:0]       tag_len;
  logic [63:0]      var_acc;
  logic             var_ok;
  logic [3:0]       var_len;
  logic [7:0]       cur;
  logic [63:0]      fix_val;
  logic [2:0]       wire_t, want_wire;
  logic             type_ok;
  logic [3:0]       pay_len;
  logic [63:0]      raw;
  logic [31:0]      u32;
  logic [63:0]      dec_value;
  logic [7:0]       dec_mask;
  logic [1:0]       dec_code;
  logic [3:0]       dec_cons;

  // Decode is purely combinational from the 16 captured bytes; it is only consumed in S_DECODE.
  always_comb begin
    tag_acc = '0;
    tag_ok  = 1'b0;
    tag_len = '0;
    for (int i = 0; i < MAX_TAG_BYTES; i++) begin
      if (!tag_ok) begin
        tag_acc = tag_acc | (TAG_W'(buf_q[i][6:0]) << (7 * i));
        if (!buf_q[i][7]) begin
          tag_ok  = 1'b1;
          tag_len = 4'(i + 1);
        end
      end
    end

    // Groups past bit 63 fall off the 64-bit accumulator by the shift itself.
    var_acc = '0;
    var_ok  = 1'b0;
    var_len = '0;
    cur     = '0;
    for (int k = 0; k < MAX_VAL_BYTES; k++) begin
      cur = buf_q[tag_len + 4'(k)];
      if (!var_ok) begin
        var_acc = var_acc | (64'(cur[6:0]) << (7 * k));
        if (!cur[7]) begin
          var_ok  = 1'b1;
          var_len = 4'(k + 1);
        end
      end
    end

    fix_val = '0;
    for (int k = 0; k < 8; k++) fix_val[8*k +: 8] = buf_q[tag_len + 4'(k)];

    wire_t    = tag_acc[2:0];
    type_ok   = 1'b1;
    want_wire = 3'd0;
    case (type_q)
      5'd3, 5'd4, 5'd5, 5'd8, 5'd13, 5'd14, 5'd17, 5'd18: want_wire = 3'd0;
      5'd1, 5'd6, 5'd16:                                  want_wire = 3'd1;
      5'd2, 5'd7, 5'd15:                                  want_wire = 3'd5;
      default:                                            type_ok   = 1'b0;
    endcase

    case (wire_t)
      3'd0:    pay_len = var_len;
      3'd1:    pay_len = 4'd8;
      3'd5:    pay_len = 4'd4;
      default: pay_len = 4'd0;
    endcase
    dec_cons = tag_len + pay_len;

    if (!tag_ok || (wire_t == 3'd0 && !var_ok))
      dec_code = 2'd3;
    else if (tag_acc[TAG_W-1:3] != (TAG_W-3)'(exp_q))
      dec_code = 2'd1;
    else if (!type_ok || wire_t != want_wire)
      dec_code = 2'd2;
    else
      dec_code = 2'd0;

    raw       = (wire_t == 3'd0) ? var_acc : fix_val;
    u32       = raw[31:0];
    dec_value = raw;
    dec_mask  = 8'hFF;
    case (type_q)
      5'd8: begin
        dec_value = {63'd0, |raw};
        dec_mask  = 8'h01;
      end
      5'd17: begin
        dec_value = {32'd0, (u32 >> 1) ^ (32'd0 - {31'd0, u32[0]})};
        dec_mask  = 8'h0F;
      end
      5'd18: dec_value = (raw >> 1) ^ (64'd0 - {63'd0, raw[0]});
      5'd2, 5'd5, 5'd7, 5'd13, 5'd14, 5'd15: begin
        dec_value = {32'd0, u32};
        dec_mask  = 8'h0F;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (en) state_d = S_RD0;
      S_RD0:    state_d = S_RDW0;
      S_RDW0:   if (dram_valid == 8'hFF) state_d = S_RD1;
      S_RD1:    state_d = S_RDW1;
      S_RDW1:   if (dram_valid == 8'hFF) state_d = S_DECODE;
      S_DECODE: state_d = (dec_code == 2'd0) ? S_WR : S_DONE;
      S_WR:     state_d = S_WRW;
      S_WRW:    if ((dram_valid & mask_q) == mask_q) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      src_q   <= '0;
      dst_q   <= '0;
      exp_q   <= '0;
      type_q  <= '0;
      buf_q   <= '0;
      value_q <= '0;
      mask_q  <= '0;
      code_q  <= '0;
      cons_q  <= '0;
    end else begin
      if (state_q == S_IDLE && en) begin
        src_q  <= src_addr;
        dst_q  <= dst_addr;
        exp_q  <= exp_field_id;
        type_q <= field_type;
      end
      if (state_q == S_RDW0 && dram_valid == 8'hFF) buf_q[7:0]  <= dram_data_in;
      if (state_q == S_RDW1 && dram_valid == 8'hFF) buf_q[15:8] <= dram_data_in;
      if (state_q == S_DECODE) begin
        value_q <= dec_value;
        mask_q  <= dec_mask;
        code_q  <= dec_code;
        cons_q  <= dec_cons;
      end
    end
  end

  always_comb begin
    ready          = (state_q == S_IDLE);
    done           = (state_q == S_DONE);
    error          = done && (code_q != 2'd0);
    err_code       = done ? code_q : 2'd0;
    bytes_consumed = done ? cons_q : 4'd0;
    next_src_addr  = done ? (src_q + 64'(cons_q)) : 64'd0;
    dram_en        = '0;
    dram_rdwr      = 1'b0;
    dram_addr      = '0;
    dram_data_out  = '0;
    case (state_q)
      S_RD0: begin
        dram_en = 8'hFF;
        for (int i = 0; i < 8; i++) dram_addr[i] = src_q + 64'(i);
      end
      S_RD1: begin
        dram_en = 8'hFF;
        for (int i = 0; i < 8; i++) dram_addr[i] = src_q + 64'(8 + i);
      end
      S_WR: begin
        dram_en   = mask_q;
        dram_rdwr = 1'b1;
        for (int i = 0; i < 8; i++) begin
          dram_addr[i]     = dst_q + 64'(i);
          dram_data_out[i] = value_q[8*i +: 8];
        end
      end
      S_WRW:   dram_rdwr = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_deser_field.sv
// tb/tb_deser_field.sv - self-checking bench for deser_field against a behavioural decode model
module tb_deser_field;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, en;
  logic [63:0]      src_addr, dst_addr;
  logic [28:0]      exp_field_id;
  logic [4:0]       field_type;
  logic             ready, done, error;
  logic [1:0]       err_code;
  logic [3:0]       bytes_consumed;
  logic [63:0]      next_src_addr;
  logic [7:0]       dram_en;
  logic             dram_rdwr;
  logic [7:0][63:0] dram_addr;
  logic [7:0][7:0]  dram_data_out;
  logic [7:0][7:0]  dram_data_in = '0;
  logic [7:0]       dram_valid = '0;

  deser_field dut (
    .clk(clk), .reset(reset), .en(en), .src_addr(src_addr), .dst_addr(dst_addr),
    .exp_field_id(exp_field_id), .field_type(field_type), .ready(ready), .done(done),
    .error(error), .err_code(err_code), .bytes_consumed(bytes_consumed),
    .next_src_addr(next_src_addr), .dram_en(dram_en), .dram_rdwr(dram_rdwr),
    .dram_addr(dram_addr), .dram_data_out(dram_data_out), .dram_data_in(dram_data_in),
    .dram_valid(dram_valid)
  );

  int total = 0;
  int bad = 0;

  // Serialized buffer seen at cur_src; written only by the stimulus process.
  logic [7:0]  sbuf [0:15];
  logic [63:0] cur_src = '0;
  int          extra_wait = 0;
  int          wpos = 0;

  // DRAM responder state; written only by the responder process.
  int               cnt = 0;
  logic [7:0]       pmask = '0;
  logic [7:0][7:0]  pdata = '0;
  logic [63:0]      roff;
  int               rd_total = 0, rd_bad_total = 0, wr_total = 0;
  logic [7:0]       wr_mask = '0;
  logic [7:0][63:0] wr_addr = '0;
  logic [7:0][7:0]  wr_data = '0;

  always @(negedge clk) begin
    dram_valid = 8'h00;
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        dram_valid   = pmask;
        dram_data_in = pdata;
      end
    end
    if (dram_en != 8'h00) begin
      pmask = dram_en;
      cnt   = 1 + extra_wait;
      if (dram_rdwr) begin
        wr_total = wr_total + 1;
        wr_mask  = dram_en;
        wr_addr  = dram_addr;
        wr_data  = dram_data_out;
        pdata    = '0;
      end else begin
        rd_total = rd_total + 1;
        for (int i = 0; i < 8; i++) begin
          roff = dram_addr[i] - cur_src;
          if (roff >= 64'd16 || roff[2:0] != 3'(i)) rd_bad_total = rd_bad_total + 1;
          pdata[i] = (roff < 64'd16) ? sbuf[roff[3:0]] : 8'hEE;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill();
    for (int i = 0; i < 16; i++) sbuf[i] = 8'($urandom);
  endtask

  task automatic put_varint(input longint unsigned v);
    do begin
      sbuf[wpos] = 8'(v % 128) | ((v >= 128) ? 8'h80 : 8'h00);
      v = v / 128;
      wpos++;
    end while (v != 0);
  endtask

  function automatic int wire_of(input int t);
    if (t inside {3, 4, 5, 8, 13, 14, 17, 18}) return 0;
    if (t inside {1, 6, 16}) return 1;
    if (t inside {2, 7, 15}) return 5;
    return -1;
  endfunction

  // Reference: protobuf decoding rules on the byte array using integer arithmetic.
  task automatic model(input int ftype, input logic [28:0] eid, output int code, output int cons,
                       output logic [7:0] mask, output logic [63:0] val);
    longint unsigned tag, u, f, lo;
    int tl, vl, wt;
    code = 0; cons = 0; mask = 8'h00; val = 64'd0;
    tag = 0; tl = 0;
    for (int i = 0; i < 5; i++) begin
      tag = tag + (64'(sbuf[i] & 8'h7f) << (7 * i));
      if (sbuf[i] < 8'd128) begin tl = i + 1; break; end
    end
    if (tl == 0) begin code = 3; return; end
    wt = int'(tag % 8);
    f  = tag / 8;
    u = 0; vl = 0;
    for (int k = 0; k < 10; k++) begin
      if (7 * k < 64) u = u | (64'(sbuf[tl + k] & 8'h7f) << (7 * k));
      if (sbuf[tl + k] < 8'd128) begin vl = k + 1; break; end
    end
    if (wt == 0 && vl == 0) code = 3;
    else if (f != 64'(eid)) code = 1;
    else if (wire_of(ftype) != wt) code = 2;
    if (code != 0) return;
    if (wt != 0) begin
      vl = (wt == 1) ? 8 : 4;
      u = 0;
      for (int k = 0; k < vl; k++) u = u | (64'(sbuf[tl + k]) << (8 * k));
    end
    cons = tl + vl;
    mask = 8'hFF;
    val  = u;
    lo   = u % 64'h1_0000_0000;
    if (ftype == 8) begin
      mask = 8'h01;
      val  = (u != 0) ? 64'd1 : 64'd0;
    end else if (ftype == 17) begin
      mask = 8'h0F;
      val  = (lo % 2 == 1) ? (64'hFFFF_FFFF - lo / 2) : lo / 2;
    end else if (ftype == 18) begin
      val  = (u % 2 == 1) ? (64'hFFFF_FFFF_FFFF_FFFF - u / 2) : u / 2;
    end else if (ftype inside {2, 5, 7, 13, 14, 15}) begin
      mask = 8'h0F;
      val  = lo;
    end
  endtask

  task automatic run_case(input string nm, input int ftype, input logic [28:0] eid,
                          input logic [63:0] src, input logic [63:0] dst, input int w);
    int code, cons, cyc, rd0, rb0, wr0;
    logic [7:0]  mask;
    logic [63:0] val;
    model(ftype, eid, code, cons, mask, val);
    extra_wait = w;
    cur_src    = src;
    rd0 = rd_total; rb0 = rd_bad_total; wr0 = wr_total;
    @(negedge clk);
    chk({nm, "_ready"}, ready, 1);
    src_addr = src; dst_addr = dst; exp_field_id = eid; field_type = 5'(ftype); en = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      en = 1'b0;
    end while (!done && cyc < 80);
    chk({nm, "_done"}, done, 1);
    if (w == 0) chk({nm, "_latency"}, 64'(cyc), (code == 0) ? 64'd8 : 64'd6);
    chk({nm, "_error"}, error, (code != 0) ? 64'd1 : 64'd0);
    chk({nm, "_err_code"}, err_code, 64'(code));
    chk({nm, "_reads"}, 64'(rd_total - rd0), 64'd2);
    chk({nm, "_rd_addr"}, 64'(rd_bad_total - rb0), 64'd0);
    if (code == 0) begin
      chk({nm, "_consumed"}, bytes_consumed, 64'(cons));
      chk({nm, "_next_src"}, next_src_addr, src + 64'(cons));
      chk({nm, "_writes"}, 64'(wr_total - wr0), 64'd1);
      chk({nm, "_mask"}, wr_mask, mask);
      for (int i = 0; i < 8; i++) begin
        if (mask[i]) begin
          chk($sformatf("%s_waddr%0d", nm, i), wr_addr[i], dst + 64'(i));
          chk($sformatf("%s_wdata%0d", nm, i), wr_data[i], val[8*i +: 8]);
        end
      end
    end else begin
      chk({nm, "_no_write"}, 64'(wr_total - wr0), 64'd0);
    end
  endtask

  initial begin
    int sup [14] = '{1, 2, 3, 4, 5, 6, 7, 8, 13, 14, 15, 16, 17, 18};
    logic [63:0] ww;
    logic seen_done, seen_en;
    int wr_before;

    reset = 1'b0; en = 1'b0; src_addr = '0; dst_addr = '0; exp_field_id = '0; field_type = '0;
    fill();
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_consumed", bytes_consumed, 0);
    chk("rst_next_src", next_src_addr, 0);
    chk("rst_dram_en", dram_en, 0);
    chk("rst_dram_rdwr", dram_rdwr, 0);
    chk("rst_dram_addr_zero", {63'd0, dram_addr === '0}, 1);
    chk("rst_dram_data_zero", {63'd0, dram_data_out === '0}, 1);
    reset = 1'b1;
    @(negedge clk);

    fill(); sbuf[0] = 8'h08; sbuf[1] = 8'h96; sbuf[2] = 8'h01;
    run_case("uint64", 4, 29'd1, 64'h2000, 64'h1000, 0);
    ww = wr_data;
    chk("uint64_word", ww, 64'h96);

    fill(); sbuf[0] = 8'h10; sbuf[1] = 8'h03;
    run_case("sint32", 17, 29'd2, 64'h3000, 64'h1100, 0);
    ww = wr_data;
    chk("sint32_word", ww[31:0], 64'hFFFF_FFFE);

    fill(); sbuf[0] = 8'h1D; sbuf[1] = 8'h78; sbuf[2] = 8'h56; sbuf[3] = 8'h34; sbuf[4] = 8'h12;
    run_case("fixed32", 7, 29'd3, 64'h3FF9, 64'h1200, 0);
    ww = wr_data;
    chk("fixed32_word", ww[31:0], 64'h1234_5678);

    fill(); sbuf[0] = 8'h08;
    for (int i = 1; i <= 9; i++) sbuf[i] = 8'hFF;
    sbuf[10] = 8'h01;
    run_case("int32_long", 5, 29'd1, 64'h4000, 64'h1300, 0);
    ww = wr_data;
    chk("int32_long_word", ww[31:0], 64'hFFFF_FFFF);

    fill(); sbuf[0] = 8'h08; sbuf[1] = 8'h05;
    run_case("id_mismatch", 4, 29'd2, 64'h5000, 64'h1400, 0);

    fill(); sbuf[0] = 8'h08;
    for (int i = 1; i <= 11; i++) sbuf[i] = 8'h80;
    run_case("val_malformed", 4, 29'd1, 64'h5100, 64'h1500, 0);

    fill(); sbuf[0] = 8'h10;
    for (int i = 1; i <= 11; i++) sbuf[i] = 8'h81;
    run_case("prec_3_over_1", 4, 29'd1, 64'h5200, 64'h1600, 0);

    fill();
    for (int i = 0; i < 5; i++) sbuf[i] = 8'hFF;
    run_case("tag_malformed", 4, 29'd1, 64'h5300, 64'h1700, 0);

    fill(); sbuf[0] = 8'h0A; sbuf[1] = 8'h00;
    run_case("unsupported", 9, 29'd1, 64'h5400, 64'h1800, 0);

    fill(); sbuf[0] = 8'h08; sbuf[1] = 8'h05;
    run_case("wire_mismatch", 1, 29'd1, 64'h5500, 64'h1900, 0);

    fill(); sbuf[0] = 8'h09;
    for (int i = 1; i <= 8; i++) sbuf[i] = 8'(i);
    run_case("fixed64_wait", 6, 29'd1, 64'h5600, 64'h1A00, 2);
    ww = wr_data;
    chk("fixed64_word", ww, 64'h0807_0605_0403_0201);

    fill(); sbuf[0] = 8'h08; sbuf[1] = 8'h80; sbuf[2] = 8'h01;
    run_case("bool", 8, 29'd1, 64'h5700, 64'h1B00, 0);

    fill(); sbuf[0] = 8'h08; sbuf[1] = 8'h05;
    run_case("sint64", 18, 29'd1, 64'h5800, 64'h1C00, 0);
    ww = wr_data;
    chk("sint64_word", ww, 64'hFFFF_FFFF_FFFF_FFFD);

    // Reset while the first read is outstanding.
    fill(); sbuf[0] = 8'h08; sbuf[1] = 8'h96; sbuf[2] = 8'h01;
    extra_wait = 3;
    cur_src = 64'h6000;
    wr_before = wr_total;
    @(negedge clk);
    src_addr = 64'h6000; dst_addr = 64'h1D00; exp_field_id = 29'd1; field_type = 5'd4; en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("abort_dram_en", dram_en, 0);
    chk("abort_ready", ready, 1);
    chk("abort_done", done, 0);
    seen_done = 1'b0; seen_en = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen_done = seen_done | done;
      seen_en   = seen_en | (dram_en != 8'h00);
    end
    chk("abort_no_done", seen_done, 0);
    chk("abort_no_traffic", seen_en, 0);
    chk("abort_no_write", 64'(wr_total - wr_before), 0);
    run_case("after_abort", 4, 29'd1, 64'h6100, 64'h1E00, 0);

    for (int n = 0; n < 40; n++) begin
      int ft, kind, wt, tpos;
      logic [28:0] fid, eid;
      longint unsigned u;
      fid = 29'($urandom) >> $urandom_range(0, 28);
      if (fid == 0) fid = 29'd1;
      kind = $urandom_range(0, 9);
      ft   = (kind == 8) ? $urandom_range(9, 12) : sup[$urandom_range(0, 13)];
      wt   = wire_of(ft);
      if (wt < 0) wt = 2;
      if (kind == 6) wt = (wt == 0) ? 5 : 0;
      fill();
      wpos = 0;
      put_varint({32'd0, fid, 3'(wt)});
      tpos = wpos;
      if (wt == 0) begin
        u = {$urandom, $urandom};
        u = u >> $urandom_range(0, 63);
        put_varint(u);
        if (kind == 9)
          for (int k = 0; k < 10; k++) sbuf[tpos + k] = sbuf[tpos + k] | 8'h80;
      end
      eid = (kind == 7) ? (fid ^ 29'd1) : fid;
      run_case($sformatf("rand%0d", n), ft, eid, {$urandom, $urandom}, {$urandom, $urandom},
               $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
